// File: rtl/sram_arb_pkg.sv
// Shared widths, read-return tags and FSM encodings
// for the SRAM access arbiter.
package sram_arb_pkg;

  localparam int ADDR_WIDTH = 19;
  localparam int DATA_WIDTH = 201;

  localparam logic TAG_UPD = 1'b0;
  localparam logic TAG_REG = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Request, SRAM command and read-return bundle of the arbiter.
// slave = arbiter side, master = requesters/controller side.
interface sram_access_arbiter_if #(
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_arb_pkg::DATA_WIDTH
);

  logic                  upd_req_valid;
  logic                  upd_req_ready;
  logic                  upd_req_rnw;
  logic [ADDR_WIDTH-1:0] upd_req_addr;
  logic [DATA_WIDTH-1:0] upd_req_wdata;

  logic                  reg_req_valid;
  logic                  reg_req_ready;
  logic [ADDR_WIDTH-1:0] reg_req_addr;

  logic                  sram_cmd_valid;
  logic                  sram_cmd_ready;
  logic                  sram_cmd_rnw;
  logic [ADDR_WIDTH-1:0] sram_cmd_addr;
  logic [DATA_WIDTH-1:0] sram_cmd_wdata;

  logic                  sram_rd_valid;
  logic [DATA_WIDTH-1:0] sram_rd_data;

  logic                  upd_rd_valid;
  logic [DATA_WIDTH-1:0] upd_rd_data;
  logic                  reg_rd_valid;
  logic [DATA_WIDTH-1:0] reg_rd_data;

  modport slave (
    input  upd_req_valid, upd_req_rnw,
    input  upd_req_addr, upd_req_wdata,
    output upd_req_ready,
    input  reg_req_valid, reg_req_addr,
    output reg_req_ready,
    output sram_cmd_valid, sram_cmd_rnw,
    output sram_cmd_addr, sram_cmd_wdata,
    input  sram_cmd_ready,
    input  sram_rd_valid, sram_rd_data,
    output upd_rd_valid, upd_rd_data,
    output reg_rd_valid, reg_rd_data
  );

  modport master (
    output upd_req_valid, upd_req_rnw,
    output upd_req_addr, upd_req_wdata,
    input  upd_req_ready,
    output reg_req_valid, reg_req_addr,
    input  reg_req_ready,
    input  sram_cmd_valid, sram_cmd_rnw,
    input  sram_cmd_addr, sram_cmd_wdata,
    output sram_cmd_ready,
    output sram_rd_valid, sram_rd_data,
    input  upd_rd_valid, upd_rd_data,
    input  reg_rd_valid, reg_rd_data
  );

endinterface

// File: rtl/sram_arb_tag_fifo.sv
// 1-bit synchronous tag FIFO recording the requester of
// each in-flight SRAM read, in issue order.
module sram_arb_tag_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_din,
  input  logic          i_pop,
  output logic          o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// SRAM command-port arbiter: update path vs host reads, tagged read return.
// SRAM_ARB_RR_EN selects strict round-robin instead of update priority.
module sram_access_arbiter #(
  parameter int ADDR_WIDTH       = sram_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH       = sram_arb_pkg::DATA_WIDTH,
  parameter int MAX_OUTSTANDING  = 8,
  parameter int REG_STARVE_LIMIT = 16
) (
  input  logic                 i_memclk,
  input  logic                 i_memreset,
  sram_access_arbiter_if.slave io_arb,
  output logic                 o_rd_orphan,
  output logic [1:0]           o_arb_state
);

  import sram_arb_pkg::*;

  arb_state_t            r_state;
  logic                  r_cmd_valid;
  logic                  r_cmd_rnw;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_wdata;

  logic                  r_upd_rd_valid;
  logic [DATA_WIDTH-1:0] r_upd_rd_data;
  logic                  r_reg_rd_valid;
  logic [DATA_WIDTH-1:0] r_reg_rd_data;
  logic                  r_orphan;

  logic w_slot_free;
  logic w_upd_can;
  logic w_reg_can;
  logic w_reg_first;
  logic w_grant_upd;
  logic w_grant_reg;
  logic w_push;
  logic w_pop;
  logic w_tag;
  logic w_full;
  logic w_empty;

  // readies stay low while reset is held
  assign w_slot_free = !i_memreset &&
                       (!r_cmd_valid || io_arb.sram_cmd_ready);

  assign w_upd_can = io_arb.upd_req_valid &&
                     (!io_arb.upd_req_rnw || !w_full);
  assign w_reg_can = io_arb.reg_req_valid && !w_full;

`ifdef SRAM_ARB_RR_EN
  logic r_last;

  assign w_reg_first = (r_last == TAG_UPD);

  always_ff @(posedge i_memclk) begin
    if (i_memreset)       r_last <= TAG_REG;
    else if (w_grant_upd) r_last <= TAG_UPD;
    else if (w_grant_reg) r_last <= TAG_REG;
  end
`else
  localparam int SW = $clog2(REG_STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;

  assign w_reg_first = (r_starve == SW'(REG_STARVE_LIMIT));

  always_ff @(posedge i_memclk) begin
    if (i_memreset) begin
      r_starve <= '0;
    end else if (w_grant_reg) begin
      r_starve <= '0;
    end else if (io_arb.reg_req_valid && !w_reg_first) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`endif

  assign w_grant_reg = w_slot_free && w_reg_can &&
                       (!w_upd_can || w_reg_first);
  assign w_grant_upd = w_slot_free && w_upd_can && !w_grant_reg;

  assign io_arb.upd_req_ready = w_grant_upd;
  assign io_arb.reg_req_ready = w_grant_reg;

  assign w_push = (w_grant_upd && io_arb.upd_req_rnw) || w_grant_reg;
  assign w_pop  = io_arb.sram_rd_valid && !w_empty;

  sram_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .i_clk   (i_memclk),
    .i_rst   (i_memreset),
    .i_push  (w_push),
    .i_din   (w_grant_reg),
    .i_pop   (w_pop),
    .o_dout  (w_tag),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count ()
  );

  always_ff @(posedge i_memclk) begin
    if (i_memreset) begin
      r_state     <= IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_rnw   <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else begin
      unique case (1'b1)
        w_grant_upd: begin
          r_state     <= ISSUE;
          r_cmd_valid <= 1'b1;
          r_cmd_rnw   <= io_arb.upd_req_rnw;
          r_cmd_addr  <= io_arb.upd_req_addr;
          r_cmd_wdata <= io_arb.upd_req_wdata;
        end
        w_grant_reg: begin
          r_state     <= ISSUE;
          r_cmd_valid <= 1'b1;
          r_cmd_rnw   <= 1'b1;
          r_cmd_addr  <= io_arb.reg_req_addr;
          r_cmd_wdata <= '0;
        end
        default: begin
          if (r_cmd_valid && !io_arb.sram_cmd_ready) begin
            r_state <= HOLD;
          end else begin
            r_state     <= IDLE;
            r_cmd_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io_arb.sram_cmd_valid = r_cmd_valid;
  assign io_arb.sram_cmd_rnw   = r_cmd_rnw;
  assign io_arb.sram_cmd_addr  = r_cmd_addr;
  assign io_arb.sram_cmd_wdata = r_cmd_wdata;
  assign o_arb_state           = r_state;

  always_ff @(posedge i_memclk) begin
    if (i_memreset) begin
      r_upd_rd_valid <= 1'b0;
      r_upd_rd_data  <= '0;
      r_reg_rd_valid <= 1'b0;
      r_reg_rd_data  <= '0;
      r_orphan       <= 1'b0;
    end else begin
      r_upd_rd_valid <= w_pop && (w_tag == TAG_UPD);
      r_reg_rd_valid <= w_pop && (w_tag == TAG_REG);
      if (w_pop && (w_tag == TAG_UPD)) begin
        r_upd_rd_data <= io_arb.sram_rd_data;
      end
      if (w_pop && (w_tag == TAG_REG)) begin
        r_reg_rd_data <= io_arb.sram_rd_data;
      end
      if (io_arb.sram_rd_valid && w_empty) begin
        r_orphan <= 1'b1;
      end
    end
  end

  assign io_arb.upd_rd_valid = r_upd_rd_valid;
  assign io_arb.upd_rd_data  = r_upd_rd_data;
  assign io_arb.reg_rd_valid = r_reg_rd_valid;
  assign io_arb.reg_rd_data  = r_reg_rd_data;
  assign o_rd_orphan         = r_orphan;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: command order/fields
// and tagged read-return routing, plus directed corner cases.
module tb_sram_access_arbiter;

  localparam int AW = 19;
  localparam int DW = 201;

  typedef struct {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic          is_reg;
    logic [DW-1:0] data;
    int            cyc;
  } ret_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       orphan;
  logic [1:0] state;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  cmd_t cmd_q[$];
  logic rd_tags[$];
  ret_t exp_rd[$];

  sram_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  sram_access_arbiter #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .MAX_OUTSTANDING  (8),
    .REG_STARVE_LIMIT (16)
  ) dut (
    .i_memclk    (clk),
    .i_memreset  (rst),
    .io_arb      (ifc),
    .o_rd_orphan (orphan),
    .o_arb_state (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // command scoreboard: push on request acceptance, pop on SRAM handshake
  always @(posedge clk) begin : mon_cmd
    cmd_t c;
    cmd_t n;
    if (!rst) begin
      if (ifc.sram_cmd_valid === 1'b1 && ifc.sram_cmd_ready === 1'b1) begin
        n_total++;
        if (cmd_q.size() == 0) begin
          $display("FAIL cmd_unexpected: got addr %h, want no command",
                   ifc.sram_cmd_addr);
        end else begin
          c = cmd_q.pop_front();
          if (ifc.sram_cmd_rnw !== c.rnw || ifc.sram_cmd_addr !== c.addr ||
              (!c.rnw && ifc.sram_cmd_wdata !== c.wdata))
            $display("FAIL cmd_fields: got rnw %b addr %h, want rnw %b addr %h",
                     ifc.sram_cmd_rnw, ifc.sram_cmd_addr, c.rnw, c.addr);
          else
            n_pass++;
        end
      end
      if (ifc.upd_req_valid === 1'b1 && ifc.upd_req_ready === 1'b1) begin
        n.rnw   = ifc.upd_req_rnw;
        n.addr  = ifc.upd_req_addr;
        n.wdata = ifc.upd_req_wdata;
        cmd_q.push_back(n);
        if (ifc.upd_req_rnw) rd_tags.push_back(1'b0);
      end
      if (ifc.reg_req_valid === 1'b1 && ifc.reg_req_ready === 1'b1) begin
        n.rnw   = 1'b1;
        n.addr  = ifc.reg_req_addr;
        n.wdata = '0;
        cmd_q.push_back(n);
        rd_tags.push_back(1'b1);
      end
    end
  end

  // read-return scoreboard: routing, data and one-cycle latency
  always @(negedge clk) begin : mon_ret
    ret_t e;
    if (!rst && (ifc.upd_rd_valid === 1'b1 || ifc.reg_rd_valid === 1'b1)) begin
      n_total++;
      if (exp_rd.size() == 0) begin
        $display("FAIL rd_unexpected: got upd %b reg %b, want none",
                 ifc.upd_rd_valid, ifc.reg_rd_valid);
      end else begin
        e = exp_rd.pop_front();
        if ({ifc.reg_rd_valid, ifc.upd_rd_valid} !== {e.is_reg, !e.is_reg} ||
            (e.is_reg ? ifc.reg_rd_data : ifc.upd_rd_data) !== e.data ||
            cyc != e.cyc + 1)
          $display("FAIL rd_route: got reg %b upd %b cyc %0d, want reg %b cyc %0d data %h",
                   ifc.reg_rd_valid, ifc.upd_rd_valid, cyc,
                   e.is_reg, e.cyc + 1, e.data);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 7; i++) d = {d[DW-33:0], 32'($urandom)};
    return d;
  endfunction

  task automatic idle_inputs();
    ifc.upd_req_valid  = 1'b0;
    ifc.upd_req_rnw    = 1'b0;
    ifc.upd_req_addr   = '0;
    ifc.upd_req_wdata  = '0;
    ifc.reg_req_valid  = 1'b0;
    ifc.reg_req_addr   = '0;
    ifc.sram_cmd_ready = 1'b1;
    ifc.sram_rd_valid  = 1'b0;
    ifc.sram_rd_data   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_q.delete();
    rd_tags.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sram_return(input logic [DW-1:0] d);
    ret_t e;
    ifc.sram_rd_valid = 1'b1;
    ifc.sram_rd_data  = d;
    if (rd_tags.size() > 0) begin
      e.is_reg = rd_tags.pop_front();
      e.data   = d;
      e.cyc    = cyc;
      exp_rd.push_back(e);
    end
    @(negedge clk);
    ifc.sram_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    ifc.upd_req_valid = 1'b1;
    ifc.reg_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({ifc.upd_req_ready, ifc.reg_req_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b%b, want 00",
               ifc.upd_req_ready, ifc.reg_req_ready);
    else n_pass++;
    n_total++;
    if ({ifc.sram_cmd_valid, ifc.sram_cmd_rnw} !== 2'b00 ||
        ifc.sram_cmd_addr !== '0 || ifc.sram_cmd_wdata !== '0)
      $display("FAIL reset_cmd: got valid %b addr %h, want 0 0",
               ifc.sram_cmd_valid, ifc.sram_cmd_addr);
    else n_pass++;
    n_total++;
    if ({ifc.upd_rd_valid, ifc.reg_rd_valid, orphan} !== 3'b000 ||
        ifc.upd_rd_data !== '0 || ifc.reg_rd_data !== '0)
      $display("FAIL reset_rd: got upd %b reg %b orphan %b, want 0 0 0",
               ifc.upd_rd_valid, ifc.reg_rd_valid, orphan);
    else n_pass++;
    n_total++;
    if (state !== 2'd0)
      $display("FAIL reset_state: got %0d, want 0", state);
    else n_pass++;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_upd_reads();
    do_reset();
    ifc.upd_req_valid = 1'b1;
    ifc.upd_req_rnw   = 1'b1;
    ifc.upd_req_addr  = 19'h10;
    #1;
    n_total++;
    if (ifc.upd_req_ready !== 1'b1)
      $display("FAIL upd_ready: got %b, want 1", ifc.upd_req_ready);
    else n_pass++;
    @(negedge clk);
    ifc.upd_req_addr = 19'h11;
    n_total++;
    if ({ifc.sram_cmd_valid, ifc.sram_cmd_rnw, ifc.sram_cmd_addr} !==
        {1'b1, 1'b1, 19'h10} || state !== 2'd1)
      $display("FAIL cmd_n1: got valid %b addr %h state %0d, want 1 10 1",
               ifc.sram_cmd_valid, ifc.sram_cmd_addr, state);
    else n_pass++;
    @(negedge clk);
    ifc.upd_req_valid = 1'b0;
    n_total++;
    if ({ifc.sram_cmd_valid, ifc.sram_cmd_addr} !== {1'b1, 19'h11})
      $display("FAIL cmd_n2: got valid %b addr %h, want 1 11",
               ifc.sram_cmd_valid, ifc.sram_cmd_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ifc.sram_cmd_valid !== 1'b0 || state !== 2'd0)
      $display("FAIL cmd_idle: got valid %b state %0d, want 0 0",
               ifc.sram_cmd_valid, state);
    else n_pass++;
    sram_return(rnd_data());
    sram_return(rnd_data());
    @(negedge clk);
    n_total++;
    if (exp_rd.size() != 0)
      $display("FAIL upd_returns: got %0d pending, want 0", exp_rd.size());
    else n_pass++;
  endtask

  task automatic test_arbitration();
    logic exp_reg;
    logic g_upd;
    logic g_reg;
    int   n;
    do_reset();
`ifdef SRAM_ARB_RR_EN
    n = 6;
`else
    n = 40;
`endif
    ifc.upd_req_valid = 1'b1;
    ifc.upd_req_rnw   = 1'b0;
    ifc.upd_req_addr  = 19'h100;
    ifc.upd_req_wdata = rnd_data();
    ifc.reg_req_valid = 1'b1;
    ifc.reg_req_addr  = 19'h40000;
    for (int i = 0; i < n; i++) begin
      #1;
`ifdef SRAM_ARB_RR_EN
      exp_reg = (i % 2) == 1;
`else
      exp_reg = (i % 17) == 16;
`endif
      g_upd = ifc.upd_req_ready;
      g_reg = ifc.reg_req_ready;
      n_total++;
      if ({g_reg, g_upd} !== {exp_reg, !exp_reg})
        $display("FAIL grant_%0d: got reg %b upd %b, want reg %b upd %b",
                 i, g_reg, g_upd, exp_reg, !exp_reg);
      else n_pass++;
      @(negedge clk);
      if (g_upd) begin
        ifc.upd_req_addr  = ifc.upd_req_addr + 1'b1;
        ifc.upd_req_wdata = rnd_data();
      end
      if (g_reg) ifc.reg_req_addr = ifc.reg_req_addr + 1'b1;
    end
    ifc.upd_req_valid = 1'b0;
    ifc.reg_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    while (rd_tags.size() > 0) sram_return(rnd_data());
    @(negedge clk);
    n_total++;
    if (exp_rd.size() != 0 || cmd_q.size() != 0)
      $display("FAIL arb_drain: got %0d rd %0d cmd pending, want 0 0",
               exp_rd.size(), cmd_q.size());
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [DW-1:0] w0;
    do_reset();
    w0 = rnd_data();
    ifc.sram_cmd_ready = 1'b0;
    ifc.upd_req_valid  = 1'b1;
    ifc.upd_req_rnw    = 1'b0;
    ifc.upd_req_addr   = 19'h2a;
    ifc.upd_req_wdata  = w0;
    @(negedge clk);
    ifc.upd_req_addr  = 19'h2b;
    ifc.upd_req_wdata = rnd_data();
    ifc.reg_req_valid = 1'b1;
    ifc.reg_req_addr  = 19'h40010;
    n_total++;
    if (state !== 2'd1)
      $display("FAIL hold_issue: got state %0d, want 1", state);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_total++;
      if (state !== 2'd2 || ifc.sram_cmd_valid !== 1'b1 ||
          ifc.sram_cmd_addr !== 19'h2a || ifc.sram_cmd_wdata !== w0 ||
          ifc.upd_req_ready !== 1'b0 || ifc.reg_req_ready !== 1'b0)
        $display("FAIL hold_%0d: got state %0d addr %h rdy %b%b, want 2 2a 00",
                 k, state, ifc.sram_cmd_addr,
                 ifc.upd_req_ready, ifc.reg_req_ready);
      else n_pass++;
    end
    ifc.sram_cmd_ready = 1'b1;
    ifc.reg_req_valid  = 1'b0;
    #1;
    n_total++;
    if (ifc.upd_req_ready !== 1'b1)
      $display("FAIL hold_release: got %b, want 1", ifc.upd_req_ready);
    else n_pass++;
    @(negedge clk);
    ifc.upd_req_valid = 1'b0;
    n_total++;
    if (state !== 2'd1 || ifc.sram_cmd_addr !== 19'h2b)
      $display("FAIL hold_next: got state %0d addr %h, want 1 2b",
               state, ifc.sram_cmd_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full();
    do_reset();
    ifc.upd_req_valid = 1'b1;
    ifc.upd_req_rnw   = 1'b1;
    ifc.upd_req_addr  = 19'h200;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifc.upd_req_addr = ifc.upd_req_addr + 1'b1;
    end
    ifc.reg_req_valid = 1'b1;
    ifc.reg_req_addr  = 19'h40020;
    #1;
    n_total++;
    if ({ifc.upd_req_ready, ifc.reg_req_ready} !== 2'b00)
      $display("FAIL full_block: got %b%b, want 00",
               ifc.upd_req_ready, ifc.reg_req_ready);
    else n_pass++;
    ifc.reg_req_valid = 1'b0;
    ifc.upd_req_rnw   = 1'b0;
    ifc.upd_req_wdata = rnd_data();
    #1;
    n_total++;
    if (ifc.upd_req_ready !== 1'b1)
      $display("FAIL full_write: got %b, want 1", ifc.upd_req_ready);
    else n_pass++;
    @(negedge clk);
    ifc.upd_req_rnw  = 1'b1;
    ifc.upd_req_addr = 19'h2ff;
    sram_return(rnd_data());
    n_total++;
    if (ifc.upd_req_ready !== 1'b1)
      $display("FAIL full_unblock: got %b, want 1", ifc.upd_req_ready);
    else n_pass++;
    @(negedge clk);
    ifc.upd_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    while (rd_tags.size() > 0) sram_return(rnd_data());
    @(negedge clk);
    n_total++;
    if (exp_rd.size() != 0 || cmd_q.size() != 0)
      $display("FAIL full_drain: got %0d rd %0d cmd pending, want 0 0",
               exp_rd.size(), cmd_q.size());
    else n_pass++;
  endtask

  task automatic test_full_same_cycle();
    do_reset();
    ifc.upd_req_valid = 1'b1;
    ifc.upd_req_rnw   = 1'b1;
    ifc.upd_req_addr  = 19'h300;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifc.upd_req_addr = ifc.upd_req_addr + 1'b1;
    end
    ifc.sram_rd_valid = 1'b1;
    ifc.sram_rd_data  = rnd_data();
    #1;
    n_total++;
    if (ifc.upd_req_ready !== 1'b0)
      $display("FAIL full_prepop: got %b, want 0", ifc.upd_req_ready);
    else n_pass++;
    ifc.upd_req_valid = 1'b0;
    ifc.sram_rd_valid = 1'b0;
    do_reset();
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_orphan();
    do_reset();
    sram_return(rnd_data());
    n_total++;
    if ({ifc.upd_rd_valid, ifc.reg_rd_valid, orphan} !== 3'b001)
      $display("FAIL orphan_set: got upd %b reg %b orphan %b, want 0 0 1",
               ifc.upd_rd_valid, ifc.reg_rd_valid, orphan);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (orphan !== 1'b1)
      $display("FAIL orphan_sticky: got %b, want 1", orphan);
    else n_pass++;
    do_reset();
    n_total++;
    if (orphan !== 1'b0)
      $display("FAIL orphan_clear: got %b, want 0", orphan);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifc.upd_req_valid = 1'b1;
    ifc.upd_req_rnw   = 1'b1;
    ifc.upd_req_addr  = 19'h400;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ifc.upd_req_addr = ifc.upd_req_addr + 1'b1;
    end
    rst = 1'b1;
    cmd_q.delete();
    rd_tags.delete();
    #1;
    n_total++;
    if (ifc.upd_req_ready !== 1'b0)
      $display("FAIL rstmid_ready: got %b, want 0", ifc.upd_req_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ifc.sram_cmd_valid !== 1'b0 || ifc.sram_cmd_addr !== '0 ||
        state !== 2'd0 || orphan !== 1'b0)
      $display("FAIL rstmid_out: got valid %b addr %h state %0d, want 0 0 0",
               ifc.sram_cmd_valid, ifc.sram_cmd_addr, state);
    else n_pass++;
    rst = 1'b0;
    ifc.upd_req_valid = 1'b0;
    sram_return(rnd_data());
    n_total++;
    if ({ifc.upd_rd_valid, orphan} !== 2'b01)
      $display("FAIL rstmid_orphan: got upd %b orphan %b, want 0 1",
               ifc.upd_rd_valid, orphan);
    else n_pass++;
    do_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_upd_reads();
    test_arbitration();
    test_hold();
    test_full();
    test_full_same_cycle();
    test_orphan();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
